// File: rtl/oka_clmul_seq.sv
// oka_clmul_seq: multi-cycle overlap-free Karatsuba carry-less multiplier.
// One shared H x H carry-less core is time-multiplexed over three states
// (z0, z2, z1), then the sub-products are combined and optionally XOR-folded
// into a running accumulator for GHASH-style chains. Valid/ready on both sides.
module oka_clmul_seq #(
   parameter int WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 acc_mode,
   input  logic                 acc_clr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-2:0]   y,
   output logic                 busy
);

   localparam int H  = WIDTH / 2;
   localparam int ZW = 2 * H - 1;
   localparam int P  = 2 * WIDTH - 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MUL0 = 3'd1;
   localparam logic [2:0] S_MUL1 = 3'd2;
   localparam logic [2:0] S_MUL2 = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic             acc_mode_q, acc_clr_q;
   logic [ZW-1:0]    z0_q, z2_q;
   logic [P-1:0]     acc_q, y_q;

   logic             accept;
   logic [H-1:0]     core_x, core_y;
   logic [ZW-1:0]    core_z;
   logic [P-1:0]     prod, acc_base, y_d;

   // Shift-and-XOR carry-less product of two H-bit polynomials.
   function automatic logic [ZW-1:0] clmul_h(input logic [H-1:0] xv, input logic [H-1:0] yv);
      logic [ZW-1:0] r;
      r = '0;
      for (int i = 0; i < H; i++) begin
         if (yv[i]) r = r ^ (ZW'(xv) << i);
      end
      return r;
   endfunction

   assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign y         = y_q;

   // Sequencer: three core passes, then hold the result until it is taken.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = S_MUL0;
         S_MUL0: state_d = S_MUL1;
         S_MUL1: state_d = S_MUL2;
         S_MUL2: state_d = S_DONE;
         S_DONE: if (out_ready) state_d = in_valid ? S_MUL0 : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Steer the shared core: low halves, high halves, then the folded halves.
   always_comb begin
      core_x = a_q[H-1:0];
      core_y = b_q[H-1:0];
      case (state_q)
         S_MUL1: begin
            core_x = a_q[WIDTH-1:H];
            core_y = b_q[WIDTH-1:H];
         end
         S_MUL2: begin
            core_x = a_q[H-1:0] ^ a_q[WIDTH-1:H];
            core_y = b_q[H-1:0] ^ b_q[WIDTH-1:H];
         end
         default: ;
      endcase
      core_z = clmul_h(core_x, core_y);
   end

   // Karatsuba recombination (core_z is z1 in MUL2) and accumulator fold.
   always_comb begin
      prod = P'(z0_q)
           ^ (P'(core_z ^ z0_q ^ z2_q) << H)
           ^ (P'(z2_q) << WIDTH);
      acc_base = acc_clr_q ? '0 : acc_q;
      y_d      = acc_mode_q ? (prod ^ acc_base) : prod;
   end

   // State, operand latch, partial products, result and accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         acc_mode_q <= 1'b0;
         acc_clr_q  <= 1'b0;
         z0_q       <= '0;
         z2_q       <= '0;
         y_q        <= '0;
         acc_q      <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q        <= a;
            b_q        <= b;
            acc_mode_q <= acc_mode;
            acc_clr_q  <= acc_clr;
         end
         if (state_q == S_MUL0) z0_q <= core_z;
         if (state_q == S_MUL1) z2_q <= core_z;
         if (state_q == S_MUL2) begin
            y_q <= y_d;
            if (acc_mode_q) acc_q <= y_d;
         end
      end
   end

endmodule
